// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the irq_ctrl interrupt controller.
// The optional LOST register is enabled by defining IRQ_CTRL_LOST_EN.
package irq_ctrl_pkg;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_CAUSE   = 3'd2;
  localparam logic [2:0] REG_EOI     = 3'd3;
  localparam logic [2:0] REG_LOST    = 3'd4;

  localparam int CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Per-source registers are at most 16 bits wide; widen them onto the bus.
  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins over every other request.
module irq_prio_enc #(
  parameter int N = 6,
  parameter int W = 4
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] sel_o,
  output logic         any_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) sel_o = W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller sharing one CPU interrupt line between sources.
// Define IRQ_CTRL_LOST_EN to add the LOST (overrun) register at word index 4.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 6,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_irq,
  input  logic [4:0]       addr,
  input  logic             we,
  input  logic [31:0]      wd,
  output logic [31:0]      rd,
  input  logic             int_ack,
  output logic             cpu_irq
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0]  cur_id_q;
  irq_state_e       state_q;
  logic             cpu_irq_q;

  logic [2:0]       regIdx;
  logic             wrPend, wrMask, wrEoi;
  logic [N_SRC-1:0] evt, req, w1cPend, ackClr;
  logic [ID_W-1:0]  sel;
  logic             reqAny, ackTake;
  logic             unusedBits;

  assign regIdx     = addr[4:2];
  assign wrPend     = we && (regIdx == REG_PENDING);
  assign wrMask     = we && (regIdx == REG_MASK);
  assign wrEoi      = we && (regIdx == REG_EOI);
  assign unusedBits = ^{addr[1:0], wd};

  assign evt     = src_irq & ~src_q;
  assign req     = pending_q & mask_q;
  assign ackTake = (state_q == ST_REQ) && int_ack;

  irq_prio_enc #(
    .N(N_SRC),
    .W(ID_W)
  ) u_prio (
    .req_i(req),
    .sel_o(sel),
    .any_o(reqAny)
  );

  // New events are ORed in last so a same-cycle set beats W1C and ack clears.
  always_comb begin
    w1cPend   = wrPend ? wd[N_SRC-1:0] : '0;
    ackClr    = (ackTake && reqAny) ? (N_SRC'(1) << sel) : '0;
    pending_d = (pending_q & ~(w1cPend | ackClr)) | evt;
    mask_d    = wrMask ? wd[N_SRC-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      src_q     <= src_irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cpu_irq_q <= 1'b0;
      cur_id_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqAny) begin
            state_q   <= ST_REQ;
            cpu_irq_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            cur_id_q  <= sel;
            state_q   <= ST_SERVICE;
            cpu_irq_q <= 1'b0;
          end else if (!reqAny) begin
            state_q   <= ST_IDLE;
            cpu_irq_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (wrEoi) state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          cpu_irq_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq = cpu_irq_q;

`ifdef IRQ_CTRL_LOST_EN
  logic [N_SRC-1:0] lost_q, lost_d;
  logic             wrLost;

  assign wrLost = we && (regIdx == REG_LOST);

  // An overrun is an event hitting a pending bit that is not leaving this cycle.
  always_comb begin
    lost_d = lost_q & ~(wrLost ? wd[N_SRC-1:0] : '0);
    lost_d = lost_d | (evt & pending_q & ~(w1cPend | ackClr));
  end

  always_ff @(posedge clk) begin
    if (reset) lost_q <= '0;
    else       lost_q <= lost_d;
  end
`endif

  always_comb begin
    rd = '0;
    case (regIdx)
      REG_PENDING: rd = zext16(16'(pending_q));
      REG_MASK:    rd = zext16(16'(mask_q));
      REG_CAUSE: begin
        rd[CAUSE_VALID_BIT] = (state_q == ST_SERVICE);
        rd[ID_W-1:0]        = cur_id_q;
      end
`ifdef IRQ_CTRL_LOST_EN
      REG_LOST:    rd = zext16(16'(lost_q));
`endif
      default:     rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected values, a negedge monitor checks them.
// Build with IRQ_CTRL_LOST_EN defined to exercise the LOST register.
module tb_irq_ctrl;

  localparam logic [4:0] A_PEND  = 5'd0;
  localparam logic [4:0] A_MASK  = 5'd4;
  localparam logic [4:0] A_CAUSE = 5'd8;
  localparam logic [4:0] A_EOI   = 5'd12;
  localparam logic [4:0] A_LOST  = 5'd16;
  localparam logic [4:0] A_UNMAP = 5'd20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        int_ack;
  logic        cpu_irq;

  typedef struct {
    bit          isIrq;
    logic [31:0] exp;
    string       name;
  } scoreEntry;

  scoreEntry sb[$];
  int        checks = 0;
  int        fails  = 0;
  logic [5:0] srcHold = 6'h00;

  irq_ctrl #(.N_SRC(6), .ID_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .src_irq(src_irq),
    .addr(addr),
    .we(we),
    .wd(wd),
    .rd(rd),
    .int_ack(int_ack),
    .cpu_irq(cpu_irq)
  );

  always #5 clk = ~clk;

  // Each call drives the inputs for one full clock cycle.
  task automatic applyStimulus(input logic [5:0] s, input logic w, input logic [4:0] a,
                               input logic [31:0] d, input logic ack);
    @(posedge clk);
    #1;
    src_irq = s;
    we      = w;
    addr    = a;
    wd      = d;
    int_ack = ack;
  endtask

  task automatic checkOutput(input bit isIrq, input logic [31:0] exp, input string nm);
    scoreEntry e;
    e.isIrq = isIrq;
    e.exp   = exp;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic readCheck(input logic [4:0] a, input logic [31:0] exp, input string nm);
    applyStimulus(srcHold, 1'b0, a, 32'h0, 1'b0);
    checkOutput(1'b0, exp, nm);
  endtask

  task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
    applyStimulus(srcHold, 1'b1, a, d, 1'b0);
  endtask

  task automatic idleCycle();
    applyStimulus(srcHold, 1'b0, A_PEND, 32'h0, 1'b0);
  endtask

  // Monitor: drains everything the stimulus queued for the current cycle.
  always @(negedge clk) begin : monitorBlk
    scoreEntry   e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = e.isIrq ? {31'b0, cpu_irq} : rd;
      checks++;
      if (act !== e.exp) begin
        fails++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    src_irq = '0;
    addr    = '0;
    we      = 1'b0;
    wd      = '0;
    int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    readCheck(A_PEND, 32'h0, "rstPending");
    checkOutput(1'b1, 32'h0, "rstIrq");
    readCheck(A_MASK, 32'h0, "rstMask");
    readCheck(A_CAUSE, 32'h0, "rstCause");

    // Single pulse on source 2, full request/ack/EOI round trip
    writeReg(A_MASK, 32'h3F);
    applyStimulus(6'h04, 1'b0, A_PEND, 32'h0, 1'b0);
    checkOutput(1'b1, 32'h0, "t1IrqPulseCyc");
    readCheck(A_PEND, 32'h04, "t1Pending");
    checkOutput(1'b1, 32'h0, "t1IrqLatency");
    applyStimulus(6'h00, 1'b0, A_CAUSE, 32'h0, 1'b0);
    checkOutput(1'b1, 32'h1, "t1IrqHigh");
    checkOutput(1'b0, 32'h0, "t1CauseInReq");
    applyStimulus(6'h00, 1'b0, A_PEND, 32'h0, 1'b1);
    checkOutput(1'b1, 32'h1, "t1IrqAckCycle");
    readCheck(A_CAUSE, 32'h8000_0002, "t1CauseSvc");
    checkOutput(1'b1, 32'h0, "t1IrqSvc");
    readCheck(A_PEND, 32'h0, "t1PendCleared");
    writeReg(A_EOI, 32'h0);
    readCheck(A_CAUSE, 32'h0000_0002, "t1CauseAfterEoi");
    checkOutput(1'b1, 32'h0, "t1IrqAfterEoi");
    idleCycle();
    checkOutput(1'b1, 32'h0, "t1IrqStaysLow");

    // Simultaneous sources 5 and 1: priority, then re-request after EOI
    applyStimulus(6'h22, 1'b0, A_PEND, 32'h0, 1'b0);
    readCheck(A_PEND, 32'h22, "t2Pending");
    checkOutput(1'b1, 32'h0, "t2IrqLatency");
    applyStimulus(6'h00, 1'b0, A_PEND, 32'h0, 1'b1);
    checkOutput(1'b1, 32'h1, "t2IrqHigh");
    readCheck(A_CAUSE, 32'h8000_0001, "t2CauseId1");
    checkOutput(1'b1, 32'h0, "t2IrqSvc");
    readCheck(A_PEND, 32'h20, "t2PendRemain");
    writeReg(A_EOI, 32'h0);
    idleCycle();
    checkOutput(1'b1, 32'h0, "t2IrqIdleCycle");
    applyStimulus(6'h00, 1'b0, A_PEND, 32'h0, 1'b1);
    checkOutput(1'b1, 32'h1, "t2IrqReassert");
    readCheck(A_CAUSE, 32'h8000_0005, "t2CauseId5");
    writeReg(A_EOI, 32'h0);
    readCheck(A_PEND, 32'h0, "t2PendEmpty");

    // Masked source, unmask, then software W1C while in REQ
    writeReg(A_MASK, 32'h0);
    applyStimulus(6'h01, 1'b0, A_PEND, 32'h0, 1'b0);
    readCheck(A_PEND, 32'h01, "t3PendMasked");
    checkOutput(1'b1, 32'h0, "t3IrqMasked1");
    idleCycle();
    checkOutput(1'b1, 32'h0, "t3IrqMasked2");
    writeReg(A_MASK, 32'h01);
    checkOutput(1'b1, 32'h0, "t3IrqMaskWrCyc");
    idleCycle();
    checkOutput(1'b1, 32'h0, "t3IrqUnmaskLat");
    applyStimulus(6'h00, 1'b1, A_PEND, 32'h01, 1'b0);
    checkOutput(1'b1, 32'h1, "t3IrqUnmasked");
    readCheck(A_PEND, 32'h0, "t3W1c");
    idleCycle();
    checkOutput(1'b1, 32'h0, "t3IrqDropped");

    // Held level on source 3: one event only; set beats a same-cycle W1C
    writeReg(A_MASK, 32'h0);
    srcHold = 6'h08;
    idleCycle();
    readCheck(A_PEND, 32'h08, "t4HeldSet");
    idleCycle();
    idleCycle();
    writeReg(A_PEND, 32'h08);
    repeat (4) idleCycle();
    readCheck(A_PEND, 32'h0, "t4HeldNoRetrigger");
    srcHold = 6'h00;
    idleCycle();
    applyStimulus(6'h08, 1'b1, A_PEND, 32'h08, 1'b0);
    readCheck(A_PEND, 32'h08, "t4SetBeatsW1c");
    writeReg(A_PEND, 32'hFF);
    readCheck(A_PEND, 32'h0, "t4PendW1cAll");

    // Reset while in service with pending bits outstanding
    writeReg(A_MASK, 32'h3F);
    applyStimulus(6'h13, 1'b0, A_PEND, 32'h0, 1'b0);
    readCheck(A_PEND, 32'h13, "t5Pending");
    applyStimulus(6'h00, 1'b0, A_PEND, 32'h0, 1'b1);
    checkOutput(1'b1, 32'h1, "t5IrqHigh");
    readCheck(A_PEND, 32'h12, "t5PendInSvc");
    readCheck(A_CAUSE, 32'h8000_0000, "t5CauseSvc");
    @(posedge clk);
    #1;
    reset   = 1'b1;
    src_irq = '0;
    we      = 1'b0;
    int_ack = 1'b0;
    addr    = A_PEND;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput(1'b1, 32'h0, "t5IrqAfterRst");
    checkOutput(1'b0, 32'h0, "t5PendAfterRst");
    readCheck(A_MASK, 32'h0, "t5MaskAfterRst");
    readCheck(A_CAUSE, 32'h0, "t5CauseAfterRst");

    // Two events on source 4 without service in between
    applyStimulus(6'h10, 1'b0, A_PEND, 32'h0, 1'b0);
    idleCycle();
    applyStimulus(6'h10, 1'b0, A_PEND, 32'h0, 1'b0);
`ifdef IRQ_CTRL_LOST_EN
    readCheck(A_LOST, 32'h10, "t6LostSet");
    writeReg(A_LOST, 32'h10);
    readCheck(A_LOST, 32'h0, "t6LostW1c");
`else
    readCheck(A_LOST, 32'h0, "t6Index4Unmapped");
`endif

    // Ack in IDLE is ignored; unmapped index and mask width
    readCheck(A_PEND, 32'h10, "t7PendBefore");
    applyStimulus(6'h00, 1'b0, A_PEND, 32'h0, 1'b1);
    readCheck(A_PEND, 32'h10, "t7AckIdleIgnored");
    readCheck(A_CAUSE, 32'h0, "t7CauseIdle");
    writeReg(A_UNMAP, 32'hFFFF_FFFF);
    readCheck(A_UNMAP, 32'h0, "t7UnmappedRead");
    writeReg(A_MASK, 32'hFFFF_FFFF);
    readCheck(A_MASK, 32'h3F, "t7MaskWidth");

    idleCycle();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboardDrain: got %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
